// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg
//   Shared definitions for the APB I2C master blocks.
//   scl_state_e      : SCL generator states (IDLE, LOW, HIGH_WAIT, HIGH)
//   DEFAULT_PRESCALE : reset-time half-period suggestion for register banks
package i2c_master_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOW       = 2'd1,
      HIGH_WAIT = 2'd2,
      HIGH      = 2'd3
   } scl_state_e;

   localparam int unsigned DEFAULT_PRESCALE_WIDTH = 16;
   localparam logic [DEFAULT_PRESCALE_WIDTH-1:0] DEFAULT_PRESCALE = 16'd124;

endpackage

// File: rtl/i2c_scl_generator_if.sv
// i2c_scl_generator_if
//   Control and bus signals of the SCL generator.
//   master : the generator itself (drives scl_oe, strobes, busy, stretch_active)
//   slave  : controller / byte engine side (drives en, prescale, start,
//            stop_req and the synchronized scl_in level)
interface i2c_scl_generator_if #(
   parameter int unsigned PRESCALE_WIDTH = 16
) ();

   logic                      en;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic                      start;
   logic                      stop_req;
   logic                      scl_in;
   logic                      scl_oe;
   logic                      scl_fall_stb;
   logic                      scl_rise_stb;
   logic                      drive_stb;
   logic                      sample_stb;
   logic                      busy;
   logic                      stretch_active;

   modport master (
      input  en, prescale, start, stop_req, scl_in,
      output scl_oe, scl_fall_stb, scl_rise_stb, drive_stb, sample_stb,
             busy, stretch_active
   );

   modport slave (
      output en, prescale, start, stop_req, scl_in,
      input  scl_oe, scl_fall_stb, scl_rise_stb, drive_stb, sample_stb,
             busy, stretch_active
   );

endinterface

// File: rtl/i2c_scl_generator_prescaler.sv
// scl_prescaler
//   Loadable half-period counter for the SCL generator.
//   clk, reset : clock, synchronous active-high reset
//   load       : clear count and latch load_val as the half-period
//   restart    : clear count, keep half-period
//   inc        : advance count (saturates at the half-period)
//   load_val   : new half-period minus one
//   tc         : current count equals half-period
//   mid_next   : count after this edge will sit at half-period/2; lets the
//                parent register its mid-phase strobes without a cycle lag
module scl_prescaler #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             restart,
   input  logic             inc,
   input  logic [WIDTH-1:0] load_val,
   output logic             tc,
   output logic             mid_next
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] half_q, half_d;

   assign tc       = (cnt_q == half_q);
   assign mid_next = (cnt_d == (half_d >> 1));

   always_comb begin
      cnt_d  = cnt_q;
      half_d = half_q;
      if (load) begin
         cnt_d  = '0;
         half_d = load_val;
      end else if (restart) begin
         cnt_d = '0;
      end else if (inc && !tc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         half_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
      end
   end

endmodule

// File: rtl/i2c_scl_generator.sv
// i2c_scl_generator
//   Drives the I2C SCL line for the APB I2C master from a programmable
//   half-period and emits phase strobes for the byte/bit engine.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : i2c_scl_generator_if.master (en, prescale, start, stop_req,
//           scl_in in; scl_oe, scl_fall_stb, scl_rise_stb, drive_stb,
//           sample_stb, busy, stretch_active out)
//   Build option I2C_SCL_CLOCK_STRETCH_EN: inserts HIGH_WAIT after each low
//   phase, holding the high phase until scl_in reads high.
module i2c_scl_generator
   import i2c_master_pkg::*;
#(
   parameter int unsigned PRESCALE_WIDTH = 16
) (
   input  logic clk,
   input  logic reset,
   i2c_scl_generator_if.master bus
);

   scl_state_e state_q, state_d;
   logic       stop_pending_q, stop_pending_d;
   logic       stop_eff;
   logic       pre_load, pre_restart, pre_inc;
   logic       pre_tc, pre_mid_next;

   logic scl_oe_q, fall_q, rise_q, drive_q, sample_q, busy_q;

   scl_prescaler #(
      .WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .load     (pre_load),
      .restart  (pre_restart),
      .inc      (pre_inc),
      .load_val (bus.prescale),
      .tc       (pre_tc),
      .mid_next (pre_mid_next)
   );

   // A stop request arriving on the last high cycle still ends this pulse.
   assign stop_eff = stop_pending_q | bus.stop_req;

   always_comb begin
      state_d        = state_q;
      stop_pending_d = stop_pending_q;
      pre_load       = 1'b0;
      pre_restart    = 1'b0;
      pre_inc        = 1'b0;
      if (!bus.en) begin
         state_d        = IDLE;
         stop_pending_d = 1'b0;
         pre_restart    = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d        = LOW;
                  pre_load       = 1'b1;
                  stop_pending_d = bus.stop_req;
               end
            end
            LOW: begin
               stop_pending_d = stop_eff;
               if (pre_tc) begin
`ifdef I2C_SCL_CLOCK_STRETCH_EN
                  state_d = HIGH_WAIT;
`else
                  state_d = HIGH;
`endif
                  pre_restart = 1'b1;
               end else begin
                  pre_inc = 1'b1;
               end
            end
`ifdef I2C_SCL_CLOCK_STRETCH_EN
            HIGH_WAIT: begin
               stop_pending_d = stop_eff;
               pre_restart    = 1'b1;
               if (bus.scl_in) begin
                  state_d = HIGH;
               end
            end
`endif
            HIGH: begin
               if (pre_tc) begin
                  pre_restart    = 1'b1;
                  stop_pending_d = 1'b0;
                  state_d        = stop_eff ? IDLE : LOW;
               end else begin
                  pre_inc        = 1'b1;
                  stop_pending_d = stop_eff;
               end
            end
            default: begin
               state_d        = IDLE;
               stop_pending_d = 1'b0;
               pre_restart    = 1'b1;
            end
         endcase
      end
   end

   // Outputs are registered from the next-state view so each strobe lines
   // up with the first cycle of the phase it marks.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         stop_pending_q <= 1'b0;
         scl_oe_q       <= 1'b0;
         fall_q         <= 1'b0;
         rise_q         <= 1'b0;
         drive_q        <= 1'b0;
         sample_q       <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         stop_pending_q <= stop_pending_d;
         scl_oe_q       <= (state_d == LOW);
         fall_q         <= (state_d == LOW)  && (state_q != LOW);
         rise_q         <= (state_d == HIGH) && (state_q != HIGH);
         drive_q        <= (state_d == LOW)  && pre_mid_next;
         sample_q       <= (state_d == HIGH) && pre_mid_next;
         busy_q         <= (state_d != IDLE);
      end
   end

`ifdef I2C_SCL_CLOCK_STRETCH_EN
   logic stretch_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         stretch_q <= 1'b0;
      end else begin
         stretch_q <= (state_d == HIGH_WAIT);
      end
   end
   assign bus.stretch_active = stretch_q;
`else
   logic unused_scl_in;
   assign unused_scl_in      = bus.scl_in;
   assign bus.stretch_active = 1'b0;
`endif

   assign bus.scl_oe       = scl_oe_q;
   assign bus.scl_fall_stb = fall_q;
   assign bus.scl_rise_stb = rise_q;
   assign bus.drive_stb    = drive_q;
   assign bus.sample_stb   = sample_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_i2c_scl_generator.sv
// tb_i2c_scl_generator
//   Self-checking bench for i2c_scl_generator. The reference model tracks the
//   position inside the current SCL period and derives every output from it
//   arithmetically. Honours I2C_SCL_CLOCK_STRETCH_EN when defined.
module tb_i2c_scl_generator;

   localparam int W   = 16;
   localparam int BIG = 1 << 30;

   logic clk = 1'b0;
   logic reset;

   i2c_scl_generator_if #(.PRESCALE_WIDTH(W)) bus ();

   i2c_scl_generator #(.PRESCALE_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // model: m_pos = cycle index inside the current period (0 = first low
   // cycle); m_hs = index of the first high cycle (unknown while stretching)
   int m_busy = 0, m_p = 0, m_pos = 0, m_hs = 0, m_stop = 0;
   int obs_busy, obs_fall, obs_rise, obs_drive, obs_sample;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int first_hs(input int h);
`ifdef I2C_SCL_CLOCK_STRETCH_EN
      return BIG;
`else
      return h;
`endif
   endfunction

   function automatic bit cur_oe();
      return (m_busy != 0) && (m_pos < m_p + 1);
   endfunction

   task automatic model_step(input bit r, e, s, sr, input int ps, input bit si);
      int h;
      if (r || !e) begin
         m_busy = 0;
         m_stop = 0;
      end else if (m_busy == 0) begin
         if (s) begin
            m_busy = 1;
            m_p    = ps;
            m_pos  = 0;
            m_stop = sr;
            m_hs   = first_hs(ps + 1);
         end
      end else begin
         h = m_p + 1;
         if (m_pos >= h && m_pos < m_hs && si) m_hs = m_pos + 1;
         if (m_pos == m_hs + h - 1) begin
            if (m_stop != 0 || sr) m_busy = 0;
            m_stop = 0;
            m_pos  = 0;
            m_hs   = first_hs(h);
         end else begin
            m_stop = m_stop | int'(sr);
            m_pos++;
         end
      end
   endtask

   task automatic step(input bit r, e, s, sr, input int ps, input bit si);
      int h, mid;
      bit b;
      reset        = r;
      bus.en       = e;
      bus.start    = s;
      bus.stop_req = sr;
      bus.prescale = ps[W-1:0];
      bus.scl_in   = si;
      model_step(r, e, s, sr, ps, si);
      @(posedge clk);
      @(negedge clk);
      h   = m_p + 1;
      mid = m_p >> 1;
      b   = (m_busy != 0);
      check_val("scl_oe",   bus.scl_oe,         b && m_pos < h);
      check_val("fall",     bus.scl_fall_stb,   b && m_pos == 0);
      check_val("rise",     bus.scl_rise_stb,   b && m_pos == m_hs);
      check_val("drive",    bus.drive_stb,      b && m_pos == mid);
      check_val("sample",   bus.sample_stb,     b && m_pos == m_hs + mid);
      check_val("busy",     bus.busy,           b);
      check_val("stretch",  bus.stretch_active, b && m_pos >= h && m_pos < m_hs);
      obs_busy   += int'(bus.busy);
      obs_fall   += int'(bus.scl_fall_stb);
      obs_rise   += int'(bus.scl_rise_stb);
      obs_drive  += int'(bus.drive_stb);
      obs_sample += int'(bus.sample_stb);
   endtask

   task automatic clear_obs();
      obs_busy = 0; obs_fall = 0; obs_rise = 0; obs_drive = 0; obs_sample = 0;
   endtask

   initial begin
      int ps_r;
      clear_obs();
      // reset state
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

      // single pulse: prescale=4, stop one cycle after start
      clear_obs();
      step(0, 1, 1, 0, 4, 1);
      step(0, 1, 0, 1, 4, 1);
      for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 4, 1);
`ifdef I2C_SCL_CLOCK_STRETCH_EN
      check_val("t1_busy_cycles", obs_busy, 11);
`else
      check_val("t1_busy_cycles", obs_busy, 10);
`endif
      check_val("t1_fall_cnt",   obs_fall,   1);
      check_val("t1_rise_cnt",   obs_rise,   1);
      check_val("t1_drive_cnt",  obs_drive,  1);
      check_val("t1_sample_cnt", obs_sample, 1);

      // prescale=9, eight periods then stop
      clear_obs();
      step(0, 1, 1, 0, 9, 1);
      for (int i = 0; i < 159; i++) step(0, 1, 0, 0, 9, 1);
      check_val("t2_fall_cnt", obs_fall, 8);
      step(0, 1, 0, 1, 9, 1);
      for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 9, 1);

      // stretch: prescale=3, scl_in held low after release
      step(0, 1, 1, 0, 3, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 3, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, (i == 5), 3, 1);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 3, 1);

      // prescale=0 with scl_in following the released line
      step(0, 1, 1, 0, 0, !cur_oe());
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, !cur_oe());
      step(0, 1, 0, 1, 0, !cur_oe());
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, !cur_oe());

      // en dropped mid-low, then clean restart
      step(0, 1, 1, 0, 6, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 6, 1);
      step(0, 0, 0, 0, 6, 1);
      step(0, 1, 0, 0, 6, 1);
      step(0, 1, 1, 0, 2, 1);
      for (int i = 0; i < 12; i++) step(0, 1, 0, (i == 8), 2, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 2, 1);

      // reset mid-high with stop pending, then a full period without stop
      step(0, 1, 1, 0, 5, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 5, 1);
      step(0, 1, 0, 1, 5, 1);
      step(1, 1, 0, 0, 5, 1);
      step(0, 1, 1, 0, 5, 1);
      for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 5, 1);
      step(0, 1, 0, 1, 5, 1);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 5, 1);

      // randomized traffic
      ps_r = 3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) ps_r = int'($urandom_range(0, 7));
         step(($urandom_range(0, 499) == 0),
              ($urandom_range(0, 49) != 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 39) == 0),
              ps_r,
              ($urandom_range(0, 1) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
